// File: rtl/uart_tx_phy_pkg.sv
// Shared definitions for the UART TX PHY: serializer state encoding and frame geometry.
package uart_tx_phy_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned FRAME_BITS = 8;
    localparam logic [2:0]  LAST_BIT   = 3'(FRAME_BITS - 1);

endpackage

// File: rtl/uart_tx_phy_fifo.sv
// Generic synchronous FIFO (power-of-2 depth) shared by the UART TX and RX PHYs.
// Pop data is the combinational head entry; a push while full is dropped.
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Fullness is judged on the registered count, before any same-cycle pop.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_phy.sv
// UART transmit PHY: TX FIFO feeding an 8N1/8N2 serializer with a programmable baud divisor.
// FIFO_DEPTH must be a power of 2 and >= 2.
module uart_tx_phy
    import uart_tx_phy_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          txen,
    input  logic                          nstop,
    input  logic [15:0]                   div,
    input  logic [$clog2(FIFO_DEPTH)-1:0] txcnt,
    input  logic                          tx_fifo_wr_en,
    input  logic [7:0]                    tx_fifo_wr_data,
    output logic                          tx_fifo_full,
    output logic                          tx_fifo_empty,
    output logic                          tx_fifo_less_than_watermark,
    output logic                          txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] div_q, div_d;
    logic        nstop_q, nstop_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic        stop2_q, stop2_d;

    logic          fifo_pop;
    logic [7:0]    fifo_rd_data;
    logic [CW-1:0] fifo_count;
    logic          baud_end;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_fifo_wr_en),
        .push_data (tx_fifo_wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (tx_fifo_full),
        .empty     (tx_fifo_empty),
        .count     (fifo_count)
    );

    assign tx_fifo_less_than_watermark = (fifo_count < {1'b0, txcnt});
    assign baud_end = (baud_q == div_q);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        div_d    = div_q;
        nstop_d  = nstop_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        stop2_d  = stop2_q;
        fifo_pop = 1'b0;
        txd      = 1'b1;
        case (state_q)
            TX_IDLE: begin
                if (txen && !tx_fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    div_d    = div;
                    nstop_d  = nstop;
                    baud_d   = '0;
                    stop2_d  = 1'b0;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                txd = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            TX_DATA: begin
                txd = shift_q[0];
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        stop2_d = 1'b0;
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            TX_STOP: begin
                // Two-stop-bit frames run the bit timer twice, tracked by stop2.
                if (baud_end) begin
                    baud_d = '0;
                    if (nstop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop2_q <= stop2_d;
        end
    end

    // Frame payload and latched settings are only consumed outside IDLE, so they carry no reset.
    always_ff @(posedge clock) begin
        shift_q <= shift_d;
        div_q   <= div_d;
        nstop_q <= nstop_d;
    end

endmodule
